// File: rtl/i2s_output_stage.sv
// i2s_output_stage
// Mono Philips I2S transmitter for the mixed voice stream.
// The block scales the incoming sample by a saturating master volume and
// latches it once per audio frame. It then sends the same 24-bit word,
// MSB first, in both 32-bit slots. BCLK and LRCLK are generated locally
// from i_clk.
module i2s_output_stage #(
    parameter int BCLK_DIV = 6          // i_clk cycles per BCLK half-period, >= 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [23:0] i_sample,
    input  logic [7:0]  i_volume,
    input  logic        i_mute,
    output logic        o_bclk,
    output logic        o_lrclk,
    output logic        o_sdata,
    output logic        o_frame_start
);

    localparam int              DIV_W    = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

    localparam logic signed [32:0] SAT_MAX = 33'sd8388607;
    localparam logic signed [32:0] SAT_MIN = -33'sd8388608;

    logic [DIV_W-1:0] div_cnt;
    logic [5:0]       bit_cnt;
    logic [23:0]      hold;

    logic             toggle_evt;
    logic             fall_evt;
    logic             frame_evt;
    logic [5:0]       bit_next;
    logic             data_bit;
    logic [23:0]      scaled;

    // Event decode: a toggle happens at the end of each half-period.
    // When BCLK is currently high, that toggle is a falling edge.
    always_comb begin
        toggle_evt = (div_cnt == DIV_LAST);
        fall_evt   = toggle_evt && o_bclk;
        bit_next   = bit_cnt + 6'd1;
        frame_evt  = fall_evt && (bit_next == 6'd0);
    end

    // Master volume: gain is volume/128, applied as a signed 33-bit product.
    // The result saturates to the 24-bit range. Mute overrides the result with 0.
    always_comb begin
        logic signed [32:0] samp_x;
        logic signed [32:0] vol_x;
        logic signed [32:0] prod;
        logic signed [32:0] shifted;
        samp_x  = {{9{i_sample[23]}}, i_sample};
        vol_x   = {25'd0, i_volume};
        prod    = samp_x * vol_x;
        shifted = prod >>> 7;
        scaled  = shifted[23:0];
        if (shifted > SAT_MAX)
            scaled = 24'h7FFFFF;
        else if (shifted < SAT_MIN)
            scaled = 24'h800000;
        if (i_mute)
            scaled = 24'd0;
    end

    // Serial data for the slot position being entered.
    // Position 0 is the one-BCLK I2S delay after the LRCLK edge.
    // Positions 1..24 carry the word MSB first, and 25..31 are padding zeros.
    always_comb begin
        logic [4:0] p;
        logic [4:0] idx;
        p        = bit_next[4:0];
        idx      = 5'd24 - p;
        data_bit = 1'b0;
        if (p >= 5'd1 && p <= 5'd24)
            data_bit = hold[idx];
    end

    // BCLK divider: the counter wraps at the end of each half-period
    // and flips the bit clock.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            div_cnt <= '0;
            o_bclk  <= 1'b0;
        end else if (toggle_evt) begin
            div_cnt <= '0;
            o_bclk  <= ~o_bclk;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Slot sequencing: LRCLK and SDATA advance only on falling BCLK.
    // This keeps both stable across every rising edge the DAC samples on.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            bit_cnt <= 6'd63;
            o_lrclk <= 1'b1;
            o_sdata <= 1'b0;
        end else if (fall_evt) begin
            bit_cnt <= bit_next;
            o_lrclk <= bit_next[5];
            o_sdata <= data_bit;
        end
    end

    // Frame start: latch the scaled sample on the same edge where LRCLK drops.
    // Position 0 always sends a zero, so the new word first appears at bit 1.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            hold          <= 24'd0;
            o_frame_start <= 1'b0;
        end else begin
            o_frame_start <= frame_evt;
            if (frame_evt)
                hold <= scaled;
        end
    end

endmodule

// File: tb/tb_i2s_output_stage.sv
// Bench for i2s_output_stage.
// A monitor deserializes the I2S stream on rising BCLK. Each frame start
// pushes the expected word, computed from the inputs present at that edge,
// onto a scoreboard. Each completed frame pops that word and compares it.
// Scenario tasks also check the last captured words against constants.
module tb_i2s_output_stage;

    localparam int BCLK_DIV = 6;
    localparam int FRAME    = 128 * BCLK_DIV;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [23:0] i_sample;
    logic [7:0]  i_volume;
    logic        i_mute;
    logic        o_bclk, o_lrclk, o_sdata, o_frame_start;

    int vectors     = 0;
    int miscompares = 0;

    i2s_output_stage #(.BCLK_DIV(BCLK_DIV)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_sample(i_sample),
        .i_volume(i_volume), .i_mute(i_mute), .o_bclk(o_bclk),
        .o_lrclk(o_lrclk), .o_sdata(o_sdata), .o_frame_start(o_frame_start)
    );

    always #5 i_clk = ~i_clk;

    // Reference gain model: gain = volume/128, with floor division and saturation.
    function automatic logic [23:0] model(logic [23:0] s, logic [7:0] v, logic m);
        longint p;
        if (m) return 24'd0;
        p = longint'($signed(s)) * longint'(v);
        p = p >>> 7;
        if (p > 64'sd8388607)  p = 64'sd8388607;
        if (p < -64'sd8388608) p = -64'sd8388608;
        return p[23:0];
    endfunction

    // Inputs as seen by the DUT at each active edge
    logic        s_reset;
    logic [23:0] s_sample;
    logic [7:0]  s_volume;
    logic        s_mute;
    always @(posedge i_clk) begin
        s_reset  <= i_reset;
        s_sample <= i_sample;
        s_volume <= i_volume;
        s_mute   <= i_mute;
    end

    logic [23:0] sb_q[$];
    int          cyc = 0, last_fs = 0, r = 0, words_done = 0;
    bit          fs_valid = 0, active = 0, pad_bad = 0;
    logic [23:0] lw, rw, last_left, last_right, exp_w;
    logic        prev_bclk = 1'b0, prev_sd = 1'b0, prev_lr = 1'b1;

    // Stream monitor and scoreboard
    always @(negedge i_clk) begin
        cyc++;
        if (s_reset === 1'b1) begin
            sb_q.delete();
            active   = 0;
            fs_valid = 0;
        end else begin
            if (o_frame_start === 1'b1) begin
                if (fs_valid) begin
                    vectors++;
                    if (cyc - last_fs != FRAME) begin
                        miscompares++;
                        $display("FAIL frame_period: got %0d cycles, want %0d", cyc - last_fs, FRAME);
                    end
                end
                fs_valid = 1;
                last_fs  = cyc;
                sb_q.push_back(model(s_sample, s_volume, s_mute));
                active  = 1;
                r       = -1;
                lw      = '0;
                rw      = '0;
                pad_bad = 0;
            end
            if (!prev_bclk && o_bclk === 1'b1) begin
                vectors++;
                if (o_sdata !== prev_sd || o_lrclk !== prev_lr) begin
                    miscompares++;
                    $display("FAIL edge_stable: sdata %b->%b lrclk %b->%b at rising BCLK, want no change",
                             prev_sd, o_sdata, prev_lr, o_lrclk);
                end
                if (active) begin
                    r++;
                    vectors++;
                    if (o_lrclk !== r[5]) begin
                        miscompares++;
                        $display("FAIL lrclk_slot: bit %0d lrclk=%b, want %b", r, o_lrclk, r[5]);
                    end
                    if (r >= 1 && r <= 24)       lw = {lw[22:0], o_sdata};
                    else if (r >= 33 && r <= 56) rw = {rw[22:0], o_sdata};
                    else if (o_sdata !== 1'b0)   pad_bad = 1;
                    if (r == 63) begin
                        words_done++;
                        last_left  = lw;
                        last_right = rw;
                        active     = 0;
                        vectors++;
                        if (sb_q.size() == 0) begin
                            miscompares++;
                            $display("FAIL scoreboard_empty: word %h completed with nothing expected", lw);
                        end else begin
                            exp_w = sb_q.pop_front();
                            if (lw !== exp_w || rw !== exp_w || pad_bad) begin
                                miscompares++;
                                $display("FAIL sb_word: left=%h right=%h pad_bad=%0d, want %h/%h pad 0",
                                         lw, rw, pad_bad, exp_w, exp_w);
                            end
                        end
                    end
                end
            end
        end
        prev_bclk = o_bclk;
        prev_sd   = o_sdata;
        prev_lr   = o_lrclk;
    end

    task automatic wait_fs();
        bit found = 0;
        for (int n = 0; n < FRAME + 50 && !found; n++) begin
            @(negedge i_clk);
            if (o_frame_start === 1'b1) found = 1;
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL fs_timeout: no frame start within %0d cycles, want one", FRAME + 50);
        end
    endtask

    task automatic wait_words(int k);
        int  target = words_done + k;
        bit  found  = 0;
        for (int n = 0; n < k * FRAME + 200 && !found; n++) begin
            @(negedge i_clk);
            if (words_done >= target) found = 1;
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL word_timeout: got %0d words, want %0d", words_done, target);
        end
    endtask

    task automatic check_word(string name, logic [23:0] exp);
        vectors++;
        if (last_left !== exp || last_right !== exp) begin
            miscompares++;
            $display("FAIL %s: left=%h right=%h, want %h", name, last_left, last_right, exp);
        end
    endtask

    // Checks reset values, then the release timing of the first BCLK rise and the first LRCLK fall.
    task automatic test_reset();
        int  n = 0, rise_at = -1;
        bit  fell = 0;
        i_reset = 1'b1; i_sample = 24'h5A5A5A; i_volume = 8'h80; i_mute = 1'b0;
        repeat (3) @(negedge i_clk);
        vectors++;
        if ({o_bclk, o_lrclk, o_sdata, o_frame_start} !== 4'b0100) begin
            miscompares++;
            $display("FAIL reset_values: bclk/lr/sd/fs=%b, want 0100", {o_bclk, o_lrclk, o_sdata, o_frame_start});
        end
        i_reset = 1'b0;
        for (int k = 0; k < 100 && !fell; k++) begin
            @(negedge i_clk);
            n++;
            if (o_bclk === 1'b1 && rise_at < 0) rise_at = n;
            if (o_lrclk === 1'b0) fell = 1;
        end
        vectors += 3;
        if (rise_at != BCLK_DIV) begin
            miscompares++;
            $display("FAIL first_rise: cycle %0d, want %0d", rise_at, BCLK_DIV);
        end
        if (!fell || n != 2 * BCLK_DIV) begin
            miscompares++;
            $display("FAIL first_lrclk_fall: cycle %0d, want %0d", n, 2 * BCLK_DIV);
        end
        if (o_frame_start !== 1'b1) begin
            miscompares++;
            $display("FAIL first_frame_start: fs=%b, want 1", o_frame_start);
        end
    endtask

    // Unity gain passes the sample through unchanged in both slots.
    task automatic test_basic();
        wait_words(2);
        check_word("unity_5a5a5a", 24'h5A5A5A);
    endtask

    // Gain and saturation vectors
    task automatic test_scaling();
        logic [23:0] smp [3] = '{24'h7FFFFF, 24'h800000, 24'hFFFC18};
        logic [7:0]  vol [3] = '{8'hFF, 8'hFF, 8'h40};
        logic [23:0] expw[3] = '{24'h7FFFFF, 24'h800000, 24'hFFFE0C};
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            i_sample = smp[i];
            i_volume = vol[i];
            wait_words(2);
            check_word($sformatf("scale_%0d", i), expw[i]);
        end
    endtask

    // Changing the input mid-frame does not disturb the word being sent.
    task automatic test_midframe();
        @(negedge i_clk);
        i_sample = 24'h123456; i_volume = 8'h80;
        wait_words(2);
        wait_fs();
        repeat (300) @(negedge i_clk);
        i_sample = 24'h654321;
        wait_words(1);
        check_word("midframe_old", 24'h123456);
        wait_words(1);
        check_word("midframe_new", 24'h654321);
    endtask

    // Mute held across exactly one frame start
    task automatic test_mute();
        @(negedge i_clk);
        i_sample = 24'h100000; i_volume = 8'h40;
        wait_words(2);
        wait_fs();
        i_mute = 1'b1;
        wait_fs();
        i_mute = 1'b0;
        wait_words(1);
        check_word("muted_frame", 24'h000000);
        wait_words(1);
        check_word("unmuted_frame", 24'h080000);
    endtask

    // A one-cycle reset in the left slot restarts framing from scratch.
    task automatic test_reset_midframe();
        int n   = 0;
        bit got = 0;
        @(negedge i_clk);
        i_sample = 24'h654321; i_volume = 8'h80;
        wait_fs();
        repeat (100) @(negedge i_clk);
        i_reset = 1'b1;
        @(negedge i_clk);
        i_reset = 1'b0;
        vectors++;
        if ({o_bclk, o_lrclk, o_sdata, o_frame_start} !== 4'b0100) begin
            miscompares++;
            $display("FAIL midreset_values: bclk/lr/sd/fs=%b, want 0100", {o_bclk, o_lrclk, o_sdata, o_frame_start});
        end
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge i_clk);
            n++;
            if (o_frame_start === 1'b1) got = 1;
        end
        vectors++;
        if (!got || n != 2 * BCLK_DIV) begin
            miscompares++;
            $display("FAIL midreset_restart: frame start at cycle %0d, want %0d", n, 2 * BCLK_DIV);
        end
        wait_words(1);
        check_word("midreset_word", 24'h654321);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_scaling();
        test_midframe();
        test_mute();
        test_reset_midframe();
        repeat (5) @(negedge i_clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/i2s_output_stage.md
# i2s_output_stage

Downstream consumer of the voice mixer's 24-bit signed mixed sample. Applies a saturating master volume, holds one sample per audio frame, and serializes it as standard Philips I2S (mono: same word in left and right slots, 32-bit slots, 24 data bits MSB-first) to an external DAC. It generates BCLK and LRCLK itself from i_clk. With default BCLK_DIV=6, the frame period is 768 i_clk cycles, equal to the mixer's output update period of 256 voices × 3 pipeline states.

## Interface
- BCLK_DIV, 6, i_clk cycles per BCLK half-period (≥2)
- i_clk  input  1  system clock
- i_reset  input  1  synchronous, active-high reset
- i_sample  input  24  signed mixed sample; level-held by upstream, sampled at frame start only
- i_volume  input  8  unsigned master gain, gain = i_volume/128 (0x80 = unity)
- i_mute  input  1  when high at frame start, latched word = 0
- o_bclk  output  1  I2S bit clock
- o_lrclk  output  1  I2S word select (0 = left, 1 = right)
- o_sdata  output  1  I2S serial data, changes on BCLK falling edge
- o_frame_start  output  1  one-i_clk pulse when a new sample is latched

## Operation
- Divider: div_cnt counts 0..BCLK_DIV-1. On the cycle where div_cnt == BCLK_DIV-1, div_cnt → 0 and o_bclk toggles (toggle event).
- Falling event is a toggle event with o_bclk == 1 before the toggle. On each falling event:
  - bit_cnt (6 bits) increments, wrapping 63→0.
  - o_lrclk ← new bit_cnt[5].
  - o_sdata ← data bit for the new position.
- Data bit: p = new bit_cnt[4:0]. For 1 ≤ p ≤ 24, output hold[24-p]. For p = 0 or 25..31, output 0. This gives the I2S one-BCLK delay after the LRCLK edge. Right slot (bit_cnt 33..56) repeats the left-slot word.
- Frame start is the falling event where new bit_cnt == 0:
  - hold ← scaled sample.
  - o_frame_start = 1 for that single i_clk cycle.
  - The register update takes effect on the same edge as LRCLK going low. Bit 1 therefore reads the new hold.
- Scaling: prod = i_sample × {1'b0, i_volume}, signed 33-bit. shifted = prod >>> 7 (arithmetic). Saturate to [-8388608, 8388607]. If i_mute, hold ← 0 instead.
- No handshake with upstream. i_sample must be stable in the cycle of the frame-start event. Both are in the i_clk domain.
- Reset mid-frame: all state returns to reset values on the next edge. The serial stream restarts cleanly, and any partial word is abandoned.

## Timing
- Reset values: o_bclk=0, o_lrclk=1, o_sdata=0, o_frame_start=0, div_cnt=0, bit_cnt=63, hold=0.
- After reset release:
  - First rising BCLK at cycle BCLK_DIV.
  - First falling event (frame start, LRCLK→0) at cycle 2·BCLK_DIV.
- BCLK period = 2·BCLK_DIV cycles. Frame = 64 BCLK = 128·BCLK_DIV cycles (768 at default).
- Latency:
  - Sample latched at frame start.
  - Its MSB appears on o_sdata 2·BCLK_DIV cycles later (bit_cnt 1).
  - Its LSB appears 24 BCLK after frame start.
  - Right-slot MSB appears 33 BCLK after frame start.
- o_lrclk and o_sdata change only on falling events, registered, same cycle as o_bclk falls. They are stable across every rising BCLK.
- Volume and mute changes take effect at the next frame start only. No mid-word glitch.

## Test plan
- Reset, i_sample=24'h5A5A5A, i_volume=0x80, i_mute=0 → deserialize on BCLK rising: left word = right word = 0x5A5A5A; bits 25..31 of each slot = 0; o_frame_start pulses every 768 cycles.
- i_sample=24'h7FFFFF, i_volume=0xFF → saturated 0x7FFFFF. i_sample=24'h800000, i_volume=0xFF → 0x800000. i_sample=-1000, i_volume=0x40 → -500.
- Change i_sample mid-frame (cycle 300 after frame start) from 0x123456 to 0x654321 → current frame still carries 0x123456 in both slots; next frame carries 0x654321.
- Assert i_mute across one frame-start event → that frame's words = 0. Deassert → the following frame carries i_sample×gain.
- Check framing: o_lrclk falls exactly 2·BCLK_DIV cycles after reset release. LRCLK high/low periods are 32 BCLK each. No o_sdata or o_lrclk transition occurs coincident with a rising BCLK.
- Assert i_reset for 1 cycle mid-left-slot → next cycle shows reset values. The next frame start occurs 2·BCLK_DIV cycles after release, with a clean full word.
